// File: rtl/address_decoder_ws_if.sv
// CPU-side bus bundle for the registered address decoder: access strobe and
// address in, ready/select/translated address and fault log out.
interface address_decoder_ws_if #(
  parameter int ADDR_W    = 16,
  parameter int OUT_W     = 15,
  parameter int N_REGIONS = 7
);
  logic                 cpu_valid;
  logic [ADDR_W-1:0]    cpu_address;
  logic                 cpu_rdy;
  logic [N_REGIONS-1:0] select;
  logic [OUT_W-1:0]     output_address;
  logic                 unmapped;
  logic [ADDR_W-1:0]    fault_address;
  logic [7:0]           fault_count;
  logic                 fault_clear;

  // CPU / bus-master view
  modport master (
    output cpu_valid, cpu_address, fault_clear,
    input  cpu_rdy, select, output_address, unmapped, fault_address, fault_count
  );

  // Decoder view
  modport slave (
    input  cpu_valid, cpu_address, fault_clear,
    output cpu_rdy, select, output_address, unmapped, fault_address, fault_count
  );
endinterface

// File: rtl/address_decoder_ws.sv
// Registered region decoder with per-region wait states and a sticky
// unmapped-access fault log. Region tables are packed with region 0 in the
// most significant slot (first in a {a, b, ...} concatenation), except
// REGION_SUB, which is a plain bit vector where bit i belongs to region i.
module address_decoder_ws #(
  parameter int                         ADDR_W      = 16,
  parameter int                         OUT_W       = 15,
  parameter int                         N_REGIONS   = 7,
  parameter logic [N_REGIONS*ADDR_W-1:0] REGION_BASE =
    {16'h7000, 16'h7001, 16'h7002, 16'h3700, 16'h0000, 16'h4000, 16'h8000},
  parameter logic [N_REGIONS*ADDR_W-1:0] REGION_LIMIT =
    {16'h7000, 16'h7001, 16'h7003, 16'h3FFF, 16'h36FF, 16'h6FFF, 16'hFFFF},
  parameter logic [N_REGIONS-1:0]        REGION_SUB  = 7'b0001000,
  parameter logic [N_REGIONS*4-1:0]      REGION_WAIT =
    {4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd1}
) (
  input  logic                clk,
  input  logic                rst_n,
  address_decoder_ws_if.slave bus
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [N_REGIONS-1:0] select_q, select_d;
  logic [OUT_W-1:0]     oaddr_q, oaddr_d;
  logic                 unmapped_q, unmapped_d;
  logic [ADDR_W-1:0]    faddr_q, faddr_d;
  logic [7:0]           fcount_q, fcount_d;

  logic                 dec_hit;
  logic [N_REGIONS-1:0] dec_sel;
  logic [OUT_W-1:0]     dec_addr;
  logic [3:0]           dec_wait;
  logic                 accept;
  logic                 unm_acc;

  function automatic logic [ADDR_W-1:0] base_of(input int i);
    return REGION_BASE[(N_REGIONS-1-i)*ADDR_W +: ADDR_W];
  endfunction

  function automatic logic [ADDR_W-1:0] limit_of(input int i);
    return REGION_LIMIT[(N_REGIONS-1-i)*ADDR_W +: ADDR_W];
  endfunction

  function automatic logic [3:0] wait_of(input int i);
    return REGION_WAIT[(N_REGIONS-1-i)*4 +: 4];
  endfunction

  // Priority decode: first matching region (lowest index) wins.
  always_comb begin
    dec_hit  = 1'b0;
    dec_sel  = '0;
    dec_addr = '0;
    dec_wait = '0;
    for (int i = 0; i < N_REGIONS; i++) begin
      if (!dec_hit && (bus.cpu_address >= base_of(i)) &&
          (bus.cpu_address <= limit_of(i))) begin
        dec_hit    = 1'b1;
        dec_sel[i] = 1'b1;
        dec_wait   = wait_of(i);
        dec_addr   = REGION_SUB[i] ? OUT_W'(bus.cpu_address - base_of(i))
                                   : bus.cpu_address[OUT_W-1:0];
      end
    end
  end

  assign accept  = (state_q == IDLE) && bus.cpu_valid;
  assign unm_acc = accept && !dec_hit;

  // Next-state logic: access acceptance, wait countdown and fault log update.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    select_d   = select_q;
    oaddr_d    = oaddr_q;
    unmapped_d = 1'b0;
    faddr_d    = faddr_q;
    fcount_d   = fcount_q;

    case (state_q)
      IDLE: begin
        if (bus.cpu_valid) begin
          select_d   = dec_sel;
          oaddr_d    = dec_addr;
          unmapped_d = !dec_hit;
          if (dec_hit && (dec_wait != 4'd0)) begin
            state_d = WAIT;
            cnt_d   = dec_wait;
          end
        end
      end
      WAIT: begin
        // New strobes are dropped here; the access in flight just counts down.
        if (cnt_q <= 4'd1) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    // A clear that lands together with a fault restarts the log at that fault.
    if (bus.fault_clear) begin
      if (unm_acc) begin
        fcount_d = 8'd1;
        faddr_d  = bus.cpu_address;
      end else begin
        fcount_d = 8'd0;
        faddr_d  = '0;
      end
    end else if (unm_acc) begin
      if (fcount_q == 8'd0) faddr_d = bus.cpu_address;
      if (fcount_q != 8'hFF) fcount_d = fcount_q + 8'd1;
    end
  end

  // State and output registers; reset aborts any access in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      select_q   <= '0;
      oaddr_q    <= '0;
      unmapped_q <= 1'b0;
      faddr_q    <= '0;
      fcount_q   <= 8'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      select_q   <= select_d;
      oaddr_q    <= oaddr_d;
      unmapped_q <= unmapped_d;
      faddr_q    <= faddr_d;
      fcount_q   <= fcount_d;
    end
  end

  assign bus.cpu_rdy        = (state_q == IDLE);
  assign bus.select         = select_q;
  assign bus.output_address = oaddr_q;
  assign bus.unmapped       = unmapped_q;
  assign bus.fault_address  = faddr_q;
  assign bus.fault_count    = fcount_q;

endmodule
